// File: rtl/reg_file.sv
// Register file with two combinational read ports and one write port.
// Also tracks which registers were written and a saturating write count.
module reg_file #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [DATA_W-1:0]    IN,
  input  logic [ADDR_W-1:0]    INADDRESS,
  input  logic                 WRITE,
  input  logic [ADDR_W-1:0]    OUT1ADDRESS,
  input  logic [ADDR_W-1:0]    OUT2ADDRESS,
  output logic [DATA_W-1:0]    OUT1,
  output logic [DATA_W-1:0]    OUT2,
  output logic [2**ADDR_W-1:0] WRITTEN,
  output logic [7:0]           WRCOUNT
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs;

  // Reset wins over a same-edge write; the count holds at 255 instead of wrapping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      regs    <= '0;
      WRITTEN <= '0;
      WRCOUNT <= '0;
    end else if (WRITE) begin
      regs[INADDRESS]    <= IN;
      WRITTEN[INADDRESS] <= 1'b1;
      if (WRCOUNT != 8'hFF)
        WRCOUNT <= WRCOUNT + 8'd1;
    end
  end

  // No write bypass: reads see the registered value only.
  assign OUT1 = regs[OUT1ADDRESS];
  assign OUT2 = regs[OUT2ADDRESS];

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: DATA_W, 8, width of each register and data port in bits.
REQ-002 Parameter: ADDR_W, 3, register address width; the register count SHALL be 2**ADDR_W (8).
REQ-003 Port: CLK  input  1  single system clock; all state SHALL update on the rising edge only.
REQ-004 Port: RESET  input  1  reset, synchronous and active-high.
REQ-005 Port: IN  input  DATA_W  write data (ALU result path).
REQ-006 Port: INADDRESS  input  ADDR_W  write register index.
REQ-007 Port: WRITE  input  1  write enable, sampled at the rising edge of CLK.
REQ-008 Port: OUT1ADDRESS  input  ADDR_W  read port 1 register index.
REQ-009 Port: OUT2ADDRESS  input  ADDR_W  read port 2 register index.
REQ-010 Port: OUT1  output  DATA_W  read port 1 data (feeds ALU OPERAND1).
REQ-011 Port: OUT2  output  DATA_W  read port 2 data (feeds ALU OPERAND2).
REQ-012 Port: WRITTEN  output  2**ADDR_W  bit i high = register i written since last reset.
REQ-013 Port: WRCOUNT  output  8  number of accepted writes since reset, saturating.

Function
REQ-014 Storage SHALL be 8 registers of DATA_W bits, indexed 0..7; no register is hardwired.
REQ-015 Reads SHALL be combinational: OUT1 = reg[OUT1ADDRESS], OUT2 = reg[OUT2ADDRESS], same-cycle response to address change.
REQ-016 Both read ports SHALL be independent; equal addresses on both ports SHALL return the same value on both.
REQ-017 Write: at rising CLK with WRITE=1 and RESET=0, reg[INADDRESS] <= IN; all other registers unchanged.
REQ-018 WRITE=0 at a rising edge SHALL leave all registers, WRITTEN and WRCOUNT unchanged; IN/INADDRESS are don't-care then.
REQ-019 No write bypass: read of INADDRESS in the write cycle SHALL return the old value until after the edge; the new value SHALL appear on OUT1/OUT2 in the cycle following the edge.
REQ-020 Accepted write SHALL set WRITTEN[INADDRESS] to 1; bits SHALL stay set until reset.
REQ-021 Accepted write SHALL increment WRCOUNT by 1; at 255 it SHALL hold at 255 (no wrap).
REQ-022 Rewriting an already-written register SHALL still increment WRCOUNT and keep WRITTEN bit at 1.
REQ-023 Outputs SHALL never be X/Z after the first reset edge, for any address value 0..7.

Reset
REQ-024 RESET=1 at a rising edge SHALL clear all 8 registers to 8'h00, WRITTEN to 0, WRCOUNT to 0.
REQ-025 RESET SHALL take priority over WRITE at the same edge: write discarded, WRCOUNT stays 0.
REQ-026 RESET asserted without a clock edge SHALL have no effect (synchronous); state before the first reset edge is undefined.
REQ-027 After reset, OUT1/OUT2 SHALL read 8'h00 for any address until written.
REQ-028 Deassertion of RESET SHALL allow a write at the very next rising edge.

Verification
REQ-029 Reset then read all addresses on both ports -> OUT1=OUT2=8'h00, WRITTEN=8'h00, WRCOUNT=0.
REQ-030 Write IN=8'h07 to r1, IN=8'h3B to r2, then OUT1ADDRESS=1, OUT2ADDRESS=2 -> OUT1=8'h07, OUT2=8'h3B, WRITTEN=8'h06, WRCOUNT=2.
REQ-031 With r4=8'h11, write IN=8'h51 to r4 while OUT1ADDRESS=4 -> OUT1=8'h11 before the edge, 8'h51 after.
REQ-032 RESET=1 and WRITE=1 (IN=8'hFF, INADDRESS=5) at same edge -> r5=8'h00, WRITTEN[5]=0, WRCOUNT=0.
REQ-033 WRITE=0, IN=8'hAA, INADDRESS=3 for 3 edges -> r3 unchanged, WRCOUNT unchanged.
REQ-034 260 consecutive writes to r7 (IN = cycle index mod 256) -> WRCOUNT=255, r7=8'h03, WRITTEN=8'h80.
